// File: rtl/instr_fetch_if.sv
// Instruction memory bus between fetch (master) and imem (slave).
// Read request is held until ack; rdata is valid in the ack cycle.
interface instr_fetch_if #(
  parameter int IMEM_AW = 10,
  parameter int DATA_W  = 32
);
  logic               imem_req;
  logic [IMEM_AW-1:0] imem_addr;
  logic               imem_ack;
  logic [DATA_W-1:0]  imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/instr_fetch.sv
// Fetch stage: reads imem for the PC and hands the word to decode.
// Optional next-word prefetch is enabled by defining FETCH_PREFETCH_EN.
module instr_fetch #(
  parameter int IMEM_AW = 10,
  parameter int DATA_W  = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       pc,
  input  logic              flush,
  instr_fetch_if.master     imem,
  output logic [DATA_W-1:0] instr,
  output logic [31:0]       instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic              fetch_busy,
  output logic              fault
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_HOLD,
    S_FAULT,
    S_PFW
  } state_t;

  state_t             r_state;
  logic               r_req;
  logic [IMEM_AW-1:0] r_addr;
  logic [DATA_W-1:0]  r_instr;
  logic [31:0]        r_instr_pc;
  logic               r_valid;
  logic               r_busy;
  logic               r_fault;
  logic [31:0]        r_req_pc;
  logic               r_drop;

  logic w_pc_ok;
  logic w_stale;

  assign w_pc_ok = (pc >> IMEM_AW) == 32'd0;
  assign w_stale = flush | r_drop | (pc != r_req_pc);

`ifdef FETCH_PREFETCH_EN
  logic               r_pf_valid;
  logic               r_pf_busy;
  logic               r_pf_drop;
  logic [DATA_W-1:0]  r_pf_data;
  logic [31:0]        r_pf_addr;
  logic [31:0]        w_nxt_pc;
  logic               w_nxt_ok;
  logic               w_pf_hit;

  assign w_nxt_pc = r_instr_pc + 32'd1;
  assign w_nxt_ok = (w_nxt_pc >> IMEM_AW) == 32'd0;
  assign w_pf_hit = r_pf_valid & ~flush & (pc == r_pf_addr);
`endif

  // Fetch FSM; every output is a register updated here.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_req      <= 1'b0;
      r_addr     <= '0;
      r_instr    <= '0;
      r_instr_pc <= '0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b1;
      r_fault    <= 1'b0;
      r_req_pc   <= '0;
      r_drop     <= 1'b0;
`ifdef FETCH_PREFETCH_EN
      r_pf_valid <= 1'b0;
      r_pf_busy  <= 1'b0;
      r_pf_drop  <= 1'b0;
      r_pf_data  <= '0;
      r_pf_addr  <= '0;
`endif
    end else begin
      unique case (r_state)
        S_IDLE: begin
`ifdef FETCH_PREFETCH_EN
          r_pf_valid <= 1'b0;
`endif
          if (!w_pc_ok) begin
            r_fault <= 1'b1;
            r_state <= S_FAULT;
          end
`ifdef FETCH_PREFETCH_EN
          else if (w_pf_hit) begin
            r_instr    <= r_pf_data;
            r_instr_pc <= pc;
            r_valid    <= 1'b1;
            r_busy     <= 1'b0;
            r_state    <= S_HOLD;
          end
`endif
          else begin
            r_req    <= 1'b1;
            r_addr   <= pc[IMEM_AW-1:0];
            r_req_pc <= pc;
            r_drop   <= 1'b0;
            r_state  <= S_REQ;
          end
        end
        S_REQ: begin
          if (imem.imem_ack) begin
            r_req <= 1'b0;
            if (w_stale) begin
              r_state <= S_IDLE;
            end else begin
              r_instr    <= imem.imem_rdata;
              r_instr_pc <= r_req_pc;
              r_valid    <= 1'b1;
              r_busy     <= 1'b0;
              r_state    <= S_HOLD;
            end
          end else if (flush) begin
            r_drop <= 1'b1;
          end
        end
        S_HOLD: begin
`ifdef FETCH_PREFETCH_EN
          if (r_pf_busy && imem.imem_ack) begin
            r_req      <= 1'b0;
            r_pf_busy  <= 1'b0;
            r_pf_valid <= ~flush;
            r_pf_data  <= imem.imem_rdata;
          end
`endif
          if (flush || instr_ready) begin
            r_valid <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_IDLE;
`ifdef FETCH_PREFETCH_EN
            if (flush) r_pf_valid <= 1'b0;
            if (r_pf_busy && !imem.imem_ack) begin
              r_pf_drop <= flush;
              r_state   <= S_PFW;
            end
`endif
          end
`ifdef FETCH_PREFETCH_EN
          else if (!r_pf_busy && !r_pf_valid && w_nxt_ok) begin
            r_req     <= 1'b1;
            r_addr    <= w_nxt_pc[IMEM_AW-1:0];
            r_pf_addr <= w_nxt_pc;
            r_pf_busy <= 1'b1;
          end
`endif
        end
        S_FAULT: begin
          if (flush && w_pc_ok) begin
            r_fault <= 1'b0;
            r_state <= S_IDLE;
          end
        end
`ifdef FETCH_PREFETCH_EN
        S_PFW: begin
          if (imem.imem_ack) begin
            r_req      <= 1'b0;
            r_pf_busy  <= 1'b0;
            r_pf_valid <= ~(flush | r_pf_drop);
            r_pf_data  <= imem.imem_rdata;
            r_state    <= S_IDLE;
          end else if (flush) begin
            r_pf_drop <= 1'b1;
          end
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign imem.imem_req  = r_req;
  assign imem.imem_addr = r_addr;
  assign instr          = r_instr;
  assign instr_pc       = r_instr_pc;
  assign instr_valid    = r_valid;
  assign fetch_busy     = r_busy;
  assign fault          = r_fault;

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage directly downstream of the program counter.
- Consumes the PC value (outPC) and reads the instruction word from a synchronous, variable-latency instruction memory using a req/ack handshake.
- Presents the word to decode with a valid/ready handshake.
- Drives fetch_busy so the control unit can hold the PC (Halt-style hold) while a fetch is outstanding. Drives fault when the PC is outside the memory range.

Parameters:
- IMEM_AW, 10, instruction memory address width in words; legal PC range 0 .. 2^IMEM_AW-1.
- DATA_W, 32, instruction word width.

Ports:
- clock  in  1  system clock; one clock domain. Reset is asynchronous and active-low.
- reset  in  1  asynchronous, active-low reset.
- pc  in  32  current PC (outPC of the PC stage).
- flush  in  1  control: branch/jump taken; discard held and in-flight instruction.
- imem_req  out  1  memory read request; held high until imem_ack.
- imem_addr  out  IMEM_AW  word address; stable while imem_req is high.
- imem_ack  in  1  memory returns data this cycle.
- imem_rdata  in  DATA_W  read data, valid when imem_ack=1.
- instr  out  DATA_W  instruction to decode.
- instr_pc  out  32  PC of instr.
- instr_valid  out  1  instr/instr_pc valid.
- instr_ready  in  1  decode accepts the instruction when instr_valid && instr_ready.
- fetch_busy  out  1  high whenever instr_valid=0; control must hold the PC.
- fault  out  1  PC out of range; sticky.

Behaviour:
- Reset (async, reset=0):
  - state=IDLE
  - imem_req=0, imem_addr=0
  - instr=0, instr_pc=0, instr_valid=0
  - fault=0, fetch_busy=1
  - any in-flight request is abandoned; memory must tolerate req dropping on reset.
- States: IDLE, REQ, HOLD, FAULT. All outputs are registered.
- IDLE:
  - if pc[31:IMEM_AW]!=0, go to FAULT.
  - otherwise latch req_pc=pc, drive imem_addr=pc[IMEM_AW-1:0], imem_req=1, and go to REQ.
- REQ:
  - imem_req and imem_addr are held until imem_ack.
  - on ack with flush=1 or pc!=req_pc: data is dropped, imem_req=0, go to IDLE (refetch).
  - otherwise: instr=imem_rdata, instr_pc=req_pc, instr_valid=1, imem_req=0, go to HOLD.
  - flush without ack: the request still completes (single outstanding, no cancel), then the data is dropped.
- HOLD:
  - instr_valid=1; instr and instr_pc are stable until accepted.
  - instr_ready=1: instr_valid=0 next cycle, go to IDLE.
  - flush=1: instr_valid=0, go to IDLE. flush has priority over instr_ready; a flushed instruction is never counted as accepted.
- FAULT:
  - fault=1, instr_valid=0, no requests issued.
  - leaves only on reset, or on flush with in-range pc, which goes to IDLE and clears fault.
- fetch_busy = !instr_valid (registered alongside instr_valid).
- Latency (no prefetch): pc stable at cycle n in IDLE → imem_req at n+1 → ack at n+1+w → instr_valid at n+2+w, where w≥0 is memory wait cycles. One IDLE bubble between consecutive instructions.
- Address boundary: pc=2^IMEM_AW-1 fetches normally; pc=2^IMEM_AW faults. No wrap-around.

Optional Feature:
FETCH_PREFETCH_EN
- Defined:
  - In HOLD, when instr_pc+1 is in range and no prefetch is held, issue a request for instr_pc+1.
  - Capture the data into pf_data and pf_addr; set pf_valid.
  - In IDLE, if pf_valid && pc==pf_addr, load instr from pf_data without a memory access. instr_valid rises the next cycle (latency 1, regardless of w). pf_valid is cleared.
  - If pc!=pf_addr, pf is discarded and a normal fetch starts.
  - A prefetch still in flight at acceptance must complete (go to REQ-wait) before the comparison.
  - flush or reset clears pf_valid.
- Not defined: no prefetch logic; behaviour exactly as above.

Test Plan:
- Reset release, pc=0, mem[0]=0xA5A5_0001, w=0, instr_ready=1 → imem_req at cycle 1 with addr 0; instr=0xA5A5_0001, instr_pc=0, instr_valid=1 at cycle 2; fetch_busy=0 same cycle.
- mem wait w=3, instr_ready=0 for 5 cycles at pc=4 → imem_req high 4 cycles, addr=4 stable; instr_valid high and instr stable until ready, then low next cycle.
- flush asserted in REQ at pc=7 before ack, pc changes to 20 → pc=7 data dropped (instr_valid stays 0); next request addr=20; instr_pc=20.
- flush and instr_ready together in HOLD → instr_valid=0 next cycle, state IDLE, next fetch uses new pc.
- IMEM_AW=10, pc=1023 then pc=1024 → 1023 fetched normally; 1024 gives fault=1, imem_req=0; flush with pc=0 clears fault, fetch of addr 0 follows.
- FETCH_PREFETCH_EN, sequential pc 0,1,2 with w=2 → after the first instruction, each next instr_valid arrives 1 cycle after IDLE (no memory wait); a jump pc 1→9 discards the prefetch and fetches addr 9 with full latency.
